// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake plus payload bundle carried between two adjacent pipeline stages.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;

  // The stage itself: consumes upstream entries, presents them downstream.
  modport slave (
    input  in_valid, in_ctrl, in_addr, in_data0, in_data1, out_ready,
    output in_ready, out_valid, out_ctrl, out_addr, out_data0, out_data1
  );

  // The surrounding pipeline: produces upstream entries, consumes downstream ones.
  modport master (
    output in_valid, in_ctrl, in_addr, in_data0, in_data1, out_ready,
    input  in_ready, out_valid, out_ctrl, out_addr, out_data0, out_data1
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional 2-entry skid buffer, flush
// with bubble gating, and a saturating stall counter. State updates on the falling edge.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int ADDR_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t           in_entry;
  entry_t           m_q, m_d;
  entry_t           s_q, s_d;
  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             emit;

  assign in_entry = '{ctrl: bus.in_ctrl, addr: bus.in_addr,
                      data0: bus.in_data0, data1: bus.in_data1};

  // With the skid buffer, readiness depends only on the holding slot being free,
  // which breaks the combinational out_ready -> in_ready path.
  assign bus.in_ready = (SKID != 0) ? ~s_valid_q : (bus.out_ready | ~m_valid_q);

  assign accept = bus.in_valid & bus.in_ready;
  assign emit   = m_valid_q & bus.out_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;

    if (flush) begin
      m_valid_d  = 1'b0;
      s_valid_d  = 1'b0;
      m_d.ctrl   = '0;
      s_d.ctrl   = '0;
    end else begin
      if (emit) begin
        if (s_valid_q) begin
          m_d       = s_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      if (accept) begin
        if (!m_valid_q || (emit && !s_valid_q)) begin
          m_d       = in_entry;
          m_valid_d = 1'b1;
        end else begin
          s_d       = in_entry;
          s_valid_d = 1'b1;
        end
      end
    end

    // Without a skid buffer the holding slot can never fill; tie it off.
    if (SKID == 0) begin
      s_d       = '0;
      s_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_valid_q && !bus.out_ready && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  // An empty or flushed stage presents a bubble: control forced low.
  assign bus.out_valid = m_valid_q;
  assign bus.out_ctrl  = m_q.ctrl & {CTRL_W{m_valid_q}};
  assign bus.out_addr  = m_q.addr;
  assign bus.out_data0 = m_q.data0;
  assign bus.out_data1 = m_q.data1;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, corner sequences
// for SKID=0 and a 2-bit counter, async reset, and randomized traffic vs a FIFO model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [10:0] ctrl;
    logic [3:0]  addr;
    logic [31:0] d0;
    logic [31:0] d1;
  } pay_t;

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [10:0] ctrl;
    logic [3:0]  addr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [15:0] st;
  } obs_t;

  typedef struct {
    logic        iv;
    logic [10:0] ctrl;
    logic [31:0] d0;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [10:0] e_ctrl;
    logic [31:0] e_d0;
    logic        e_ir;
    logic [15:0] e_st;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fl0 = 1'b0, fl1 = 1'b0, fl2 = 1'b0;
  logic [15:0] st0, st1;
  logic [1:0]  st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(11), .ADDR_W(4)) bus0 ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(11), .ADDR_W(4)) bus1 ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(11), .ADDR_W(4)) bus2 ();

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(11), .ADDR_W(4), .SKID(0), .CNT_W(16)) u_flop (
    .clk(clk), .reset(reset), .flush(fl0), .bus(bus0), .stall_cnt(st0));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(11), .ADDR_W(4), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .reset(reset), .flush(fl1), .bus(bus1), .stall_cnt(st1));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(11), .ADDR_W(4), .SKID(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(fl2), .bus(bus2), .stall_cnt(st2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pay_t mkpay(input logic [10:0] ctrl, input logic [31:0] d0);
    return '{ctrl: ctrl, addr: d0[3:0], d0: d0, d1: ~d0};
  endfunction

  task automatic drive(input int k, input logic iv, input pay_t p, input logic ordy, input logic fl);
    case (k)
      0: begin
        bus0.in_valid = iv; bus0.in_ctrl = p.ctrl; bus0.in_addr = p.addr;
        bus0.in_data0 = p.d0; bus0.in_data1 = p.d1; bus0.out_ready = ordy; fl0 = fl;
      end
      1: begin
        bus1.in_valid = iv; bus1.in_ctrl = p.ctrl; bus1.in_addr = p.addr;
        bus1.in_data0 = p.d0; bus1.in_data1 = p.d1; bus1.out_ready = ordy; fl1 = fl;
      end
      default: begin
        bus2.in_valid = iv; bus2.in_ctrl = p.ctrl; bus2.in_addr = p.addr;
        bus2.in_data0 = p.d0; bus2.in_data1 = p.d1; bus2.out_ready = ordy; fl2 = fl;
      end
    endcase
  endtask

  function automatic obs_t sample(input int k);
    obs_t o;
    case (k)
      0: o = '{ov: bus0.out_valid, ir: bus0.in_ready, ctrl: bus0.out_ctrl, addr: bus0.out_addr,
               d0: bus0.out_data0, d1: bus0.out_data1, st: st0};
      1: o = '{ov: bus1.out_valid, ir: bus1.in_ready, ctrl: bus1.out_ctrl, addr: bus1.out_addr,
               d0: bus1.out_data0, d1: bus1.out_data1, st: st1};
      default: o = '{ov: bus2.out_valid, ir: bus2.in_ready, ctrl: bus2.out_ctrl, addr: bus2.out_addr,
                     d0: bus2.out_data0, d1: bus2.out_data1, st: {14'd0, st2}};
    endcase
    return o;
  endfunction

  // Output data is only meaningful (and only checked) while out_valid is high.
  task automatic check_out(input string tag, input int k, input logic e_ov, input pay_t e_p,
                           input logic [15:0] e_st);
    obs_t o = sample(k);
    check({tag, ".out_valid"}, 64'(o.ov), 64'(e_ov));
    check({tag, ".out_ctrl"}, 64'(o.ctrl), 64'(e_ov ? e_p.ctrl : 11'h0));
    if (e_ov) begin
      check({tag, ".out_addr"}, 64'(o.addr), 64'(e_p.addr));
      check({tag, ".out_data0"}, 64'(o.d0), 64'(e_p.d0));
      check({tag, ".out_data1"}, 64'(o.d1), 64'(e_p.d1));
    end
    check({tag, ".stall_cnt"}, 64'(o.st), 64'(e_st));
  endtask

  task automatic check_ir(input string tag, input int k, input logic e_ir);
    obs_t o = sample(k);
    check({tag, ".in_ready"}, 64'(o.ir), 64'(e_ir));
  endtask

  // Inputs change just after the rising edge; the stage updates on the falling edge.
  task automatic edge_sync();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(k, 1'b0, '0, 1'b0, 1'b0);
  endtask

  vec_t vt[17];
  pay_t mq[2][$];
  logic [15:0] mst[2];
  logic r_iv[2], r_or[2], r_fl[2], r_ir[2];
  pay_t r_p[2];

  initial begin
    // Per-edge table for the skid instance; expectations are the state after that edge.
    //           iv    ctrl     d0     ordy  fl    e_ov  e_ctrl   e_d0   e_ir  e_st
    vt[0]  = '{1'b1, 11'h011, 32'h11, 1'b1, 1'b0, 1'b1, 11'h011, 32'h11, 1'b1, 16'd0};
    vt[1]  = '{1'b1, 11'h022, 32'h22, 1'b1, 1'b0, 1'b1, 11'h022, 32'h22, 1'b1, 16'd0};
    vt[2]  = '{1'b1, 11'h033, 32'h33, 1'b1, 1'b0, 1'b1, 11'h033, 32'h33, 1'b1, 16'd0};
    vt[3]  = '{1'b1, 11'h044, 32'h44, 1'b1, 1'b0, 1'b1, 11'h044, 32'h44, 1'b1, 16'd0};
    vt[4]  = '{1'b0, 11'h000, 32'h00, 1'b1, 1'b0, 1'b0, 11'h000, 32'h00, 1'b1, 16'd0};
    vt[5]  = '{1'b1, 11'h00A, 32'h0A, 1'b0, 1'b0, 1'b1, 11'h00A, 32'h0A, 1'b1, 16'd0};
    vt[6]  = '{1'b1, 11'h00B, 32'h0B, 1'b0, 1'b0, 1'b1, 11'h00A, 32'h0A, 1'b0, 16'd1};
    vt[7]  = '{1'b1, 11'h00C, 32'h0C, 1'b0, 1'b0, 1'b1, 11'h00A, 32'h0A, 1'b0, 16'd2};
    vt[8]  = '{1'b0, 11'h000, 32'h00, 1'b1, 1'b0, 1'b1, 11'h00B, 32'h0B, 1'b1, 16'd2};
    vt[9]  = '{1'b0, 11'h000, 32'h00, 1'b1, 1'b0, 1'b0, 11'h000, 32'h00, 1'b1, 16'd2};
    vt[10] = '{1'b1, 11'h00A, 32'h0A, 1'b0, 1'b0, 1'b1, 11'h00A, 32'h0A, 1'b1, 16'd2};
    vt[11] = '{1'b1, 11'h00B, 32'h0B, 1'b0, 1'b0, 1'b1, 11'h00A, 32'h0A, 1'b0, 16'd3};
    vt[12] = '{1'b1, 11'h7FF, 32'h77, 1'b0, 1'b1, 1'b0, 11'h000, 32'h00, 1'b1, 16'd3};
    vt[13] = '{1'b0, 11'h000, 32'h00, 1'b1, 1'b0, 1'b0, 11'h000, 32'h00, 1'b1, 16'd3};
    vt[14] = '{1'b1, 11'h005, 32'h55, 1'b1, 1'b0, 1'b1, 11'h005, 32'h55, 1'b1, 16'd3};
    vt[15] = '{1'b1, 11'h006, 32'h66, 1'b1, 1'b1, 1'b0, 11'h000, 32'h00, 1'b1, 16'd3};
    vt[16] = '{1'b0, 11'h000, 32'h00, 1'b1, 1'b0, 1'b0, 11'h000, 32'h00, 1'b1, 16'd3};

    idle_all();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) begin
      check_out($sformatf("reset%0d", k), k, 1'b0, '0, 16'd0);
      check_ir($sformatf("reset%0d", k), k, 1'b1);
    end

    for (int i = 0; i < 17; i++) begin
      drive(1, vt[i].iv, mkpay(vt[i].ctrl, vt[i].d0), vt[i].ordy, vt[i].fl);
      edge_sync();
      check_out($sformatf("vec%0d", i), 1, vt[i].e_ov, mkpay(vt[i].e_ctrl, vt[i].e_d0), vt[i].e_st);
      check_ir($sformatf("vec%0d", i), 1, vt[i].e_ir);
    end
    drive(1, 1'b0, '0, 1'b0, 1'b0);

    // SKID=0: combinational in_ready and same-edge replacement.
    drive(0, 1'b1, mkpay(11'h001, 32'h21), 1'b0, 1'b0);
    #1 check_ir("flop.empty", 0, 1'b1);
    edge_sync();
    check_out("flop.load", 0, 1'b1, mkpay(11'h001, 32'h21), 16'd0);
    check_ir("flop.held", 0, 1'b0);
    drive(0, 1'b1, mkpay(11'h002, 32'h22), 1'b1, 1'b0);
    #1 check_ir("flop.ready", 0, 1'b1);
    edge_sync();
    check_out("flop.replace", 0, 1'b1, mkpay(11'h002, 32'h22), 16'd0);
    drive(0, 1'b0, '0, 1'b1, 1'b0);
    edge_sync();
    check_out("flop.drain", 0, 1'b0, '0, 16'd0);

    // CNT_W=2: counter saturates at 3 without wrapping.
    drive(2, 1'b1, mkpay(11'h003, 32'h99), 1'b0, 1'b0);
    edge_sync();
    check_out("sat.load", 2, 1'b1, mkpay(11'h003, 32'h99), 16'd0);
    drive(2, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      edge_sync();
      check_out($sformatf("sat%0d", i), 2, 1'b1, mkpay(11'h003, 32'h99), (i < 3) ? 16'(i + 1) : 16'd3);
    end

    // Fill the skid stage, then pull reset between falling edges.
    drive(1, 1'b1, mkpay(11'h0AA, 32'hA0), 1'b0, 1'b0);
    edge_sync();
    drive(1, 1'b1, mkpay(11'h0BB, 32'hB0), 1'b0, 1'b0);
    edge_sync();
    check_out("full", 1, 1'b1, mkpay(11'h0AA, 32'hA0), 16'd4);
    check_ir("full", 1, 1'b0);
    reset = 1'b0;
    #1;
    check_out("arst.skid", 1, 1'b0, '0, 16'd0);
    check_ir("arst.skid", 1, 1'b1);
    check_out("arst.sat", 2, 1'b0, '0, 16'd0);
    idle_all();
    #2 reset = 1'b1;
    edge_sync();
    check_out("arst.release", 1, 1'b0, '0, 16'd0);
    check_ir("arst.release", 1, 1'b1);

    // Randomized traffic on both flavours against a FIFO model of capacity 2 (skid) or 1.
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mst[k] = 16'd0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        r_iv[k] = ($urandom_range(0, 3) != 0);
        r_or[k] = ($urandom_range(0, 2) != 0);
        r_fl[k] = ($urandom_range(0, 24) == 0);
        r_p[k].ctrl = 11'($urandom);
        r_p[k].addr = 4'($urandom);
        r_p[k].d0   = $urandom;
        r_p[k].d1   = $urandom;
        drive(k, r_iv[k], r_p[k], r_or[k], r_fl[k]);
        r_ir[k] = (k == 1) ? (mq[k].size() < 2) : (r_or[k] || (mq[k].size() == 0));
      end
      #1;
      for (int k = 0; k < 2; k++) check_ir($sformatf("rnd%0d.c%0d", k, c), k, r_ir[k]);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (r_fl[k]) begin
          mq[k].delete();
        end else begin
          if ((mq[k].size() != 0) && !r_or[k] && (mst[k] != 16'hFFFF)) mst[k]++;
          if ((mq[k].size() != 0) && r_or[k]) void'(mq[k].pop_front());
          if (r_iv[k] && r_ir[k]) mq[k].push_back(r_p[k]);
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        check_out($sformatf("rnd%0d.c%0d", k, c), k, mq[k].size() != 0,
                  (mq[k].size() != 0) ? mq[k][0] : '0, mst[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
